// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth digit sequencer: digit code, FSM state
// and the triplet-to-digit mapping.
package booth_pkg;

    typedef struct packed {
        logic neg;
        logic zero;
        logic one;
        logic two;
    } digit_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam digit_t DIGIT_NONE = '0;

    // Triplet is (B[2i+1], B[2i], B[2i-1]); digit value is B[2i-1] + B[2i] - 2*B[2i+1].
    function automatic digit_t encode_triplet(input logic [2:0] t);
        digit_t d;
        d = DIGIT_NONE;
        case (t)
            3'b000, 3'b111: d.zero = 1'b1;
            3'b001, 3'b010: d.one  = 1'b1;
            3'b011:         d.two  = 1'b1;
            3'b100: begin
                d.two = 1'b1;
                d.neg = 1'b1;
            end
            default: begin
                d.one = 1'b1;
                d.neg = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_digit_seq_if.sv
// Operand handshake and Booth digit stream bundle for booth_digit_seq.
interface booth_digit_seq_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned NUM_DIGITS = WIDTH / 2;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] B;
    logic             dig_valid;
    logic             dig_ready;
    logic             neg;
    logic             zero;
    logic             one;
    logic             two;
    logic [IDX_W-1:0] dig_idx;
    logic             dig_last;

    modport master (
        output in_valid, B, dig_ready,
        input  in_ready, dig_valid, neg, zero, one, two, dig_idx, dig_last
    );

    modport slave (
        input  in_valid, B, dig_ready,
        output in_ready, dig_valid, neg, zero, one, two, dig_idx, dig_last
    );

endinterface

// File: rtl/booth_enc_digit.sv
// Combinational radix-4 Booth recoding of one multiplier bit triplet.
module booth_enc_digit
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output digit_t     code
);

    assign code = encode_triplet(triplet);

endmodule

// File: rtl/booth_digit_seq.sv
// Sequential radix-4 Booth encoder: latches one operand, streams its digits LSB first.
// Optional macro BOOTH_SKIP_ZERO_EN: skip zero digits except the final one.
module booth_digit_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    booth_digit_seq_if.slave  bus
);

    localparam int unsigned NUM_DIGITS = WIDTH / 2;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [WIDTH:0] b_ext;
    digit_t         enc  [NUM_DIGITS];
    digit_t         digs [NUM_DIGITS];

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             load;
    digit_t           code_q, code_next;
    logic             last_q, last_next;
    logic [IDX_W-1:0] first_idx, adv_idx;

    assign b_ext = {bus.B, 1'b0};

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        booth_enc_digit u_enc (
            .triplet (b_ext[2*g+2 -: 3]),
            .code    (enc[g])
        );
    end

`ifdef BOOTH_SKIP_ZERO_EN
    logic [IDX_W-1:0] skip_idx;

    // One priority search serves both the load (over fresh codes, from 0) and
    // the advance (over latched codes, from idx+1); the last digit is the fallback.
    always_comb begin
        int unsigned from_pos;
        logic        found;
        from_pos = (state == IDLE) ? 0 : 32'(idx) + 1;
        found    = 1'b0;
        skip_idx = LAST_IDX;
        for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
            if (!found && j >= from_pos &&
                !((state == IDLE) ? enc[j].zero : digs[j].zero)) begin
                skip_idx = IDX_W'(j);
                found    = 1'b1;
            end
        end
    end

    assign first_idx = skip_idx;
    assign adv_idx   = skip_idx;
`else
    assign first_idx = '0;
    assign adv_idx   = idx + IDX_W'(1);
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                    idx_next   = first_idx;
                end
            end
            RUN: begin
                if (bus.dig_ready) begin
                    if (idx == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = adv_idx;
                    end
                end
            end
        endcase

        code_next = DIGIT_NONE;
        if (state_next == RUN) begin
            code_next = load ? enc[idx_next] : digs[idx_next];
        end
        last_next = (state_next == RUN) && (idx_next == LAST_IDX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            code_q <= DIGIT_NONE;
            last_q <= 1'b0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            code_q <= code_next;
            last_q <= last_next;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            digs <= enc;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.dig_valid = (state == RUN);
    assign bus.neg       = code_q.neg;
    assign bus.zero      = code_q.zero;
    assign bus.one       = code_q.one;
    assign bus.two       = code_q.two;
    assign bus.dig_idx   = idx;
    assign bus.dig_last  = last_q;

endmodule

// File: tb/tb_booth_digit_seq.sv
// Self-checking bench for booth_digit_seq against an arithmetic Booth digit model.
module tb_booth_digit_seq;

    localparam int unsigned WIDTH = 16;
    localparam int          N     = WIDTH / 2;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    booth_digit_seq_if #(.WIDTH(WIDTH)) bus ();

    booth_digit_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, bus.dig_valid, 0);
        check({tag, "_ready"}, bus.in_ready, 1);
        check({tag, "_neg"},   bus.neg, 0);
        check({tag, "_zero"},  bus.zero, 0);
        check({tag, "_one"},   bus.one, 0);
        check({tag, "_two"},   bus.two, 0);
        check({tag, "_last"},  bus.dig_last, 0);
    endtask

    // Drives one operand and follows its stream; the model derives each digit
    // as B[2i-1] + B[2i] - 2*B[2i+1] and the stream must sum back to signed B.
    task automatic run_op(input logic [15:0] b, input bit rand_ready,
                          input int stall_idx, input bit poke);
        logic [16:0] bext;
        int          idxs[$];
        int          vals[$];
        int          p, budget, stalls, mag, obs_d;
        longint      sum;
        bit          r;
        bext = {b, 1'b0};
        for (int i = 0; i < N; i++) begin
            int d;
            d = int'(bext[2*i]) + int'(bext[2*i+1]) - 2 * int'(bext[2*i+2]);
`ifdef BOOTH_SKIP_ZERO_EN
            if (d != 0 || i == N - 1) begin
                idxs.push_back(i);
                vals.push_back(d);
            end
`else
            idxs.push_back(i);
            vals.push_back(d);
`endif
        end

        check("idle_in_ready", bus.in_ready, 1);
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.B        = 16'($urandom);

        p = 0; budget = 0; stalls = 0; sum = 0;
        while (p < idxs.size() && budget < 200) begin
            budget++;
            mag = (vals[p] < 0) ? -vals[p] : vals[p];
            check("dig_valid", bus.dig_valid, 1);
            check("run_in_ready", bus.in_ready, 0);
            check("dig_idx", bus.dig_idx, idxs[p]);
            check("dig_last", bus.dig_last, (idxs[p] == N - 1) ? 1 : 0);
            check("neg", bus.neg, (vals[p] < 0) ? 1 : 0);
            check("zero", bus.zero, (mag == 0) ? 1 : 0);
            check("one", bus.one, (mag == 1) ? 1 : 0);
            check("two", bus.two, (mag == 2) ? 1 : 0);
            obs_d = bus.one ? 1 : (bus.two ? 2 : 0);
            if (bus.neg) obs_d = -obs_d;

            r = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            if (idxs[p] == stall_idx && stalls < 3) begin
                r = 1'b0;
                stalls++;
            end
            if (poke && !r) begin
                bus.in_valid = 1'b1;
                bus.B        = 16'($urandom);
            end
            bus.dig_ready = r;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (r) begin
                sum += longint'(obs_d) * (longint'(1) << (2 * int'(bus.dig_idx === 'x ? 0 : idxs[p])));
                p++;
            end
        end
        check("stream_complete", p, idxs.size());
        check_quiet("after_last");
        check("reconstruct", sum, longint'($signed(b)));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.B         = '0;
        bus.dig_ready = 1'b0;
        @(posedge clk); #1;
        check_quiet("reset");
        check("reset_idx", bus.dig_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h0003, 1'b0, -1, 1'b0);
        run_op(16'h8000, 1'b0, -1, 1'b0);
        run_op(16'hFFFF, 1'b0, -1, 1'b0);
        run_op(16'h5555, 1'b0, -1, 1'b0);
        run_op(16'h0000, 1'b0, -1, 1'b0);
        run_op(16'h7FFF, 1'b0, -1, 1'b0);
        run_op(16'h1234, 1'b0, 2, 1'b1);

        // Reset in the middle of a stream must abort it for good.
        bus.B         = 16'h5555;
        bus.in_valid  = 1'b1;
        bus.dig_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 20 && bus.dig_idx !== 3'd4; k++) begin
            @(posedge clk); #1;
        end
        check("rst_reached_idx4", bus.dig_idx, 4);
        rst = 1'b1;
        #1;
        check_quiet("async_rst");
        check("async_rst_idx", bus.dig_idx, 0);
        @(posedge clk); #1;
        check_quiet("rst_held");
        rst = 1'b0;
        @(posedge clk); #1;
        check_quiet("no_resume");
        run_op(16'h0001, 1'b0, -1, 1'b0);

        for (int t = 0; t < 4000; t++) begin
            run_op(16'($urandom), 1'b1, -1, ($urandom_range(7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
